div_ctrl: RTL and testbench

Multi-cycle divide sequencer for the EX stage. It accepts a DIV/DIVU request from the ALU decode, latches the operands, and runs the unsigned core `div_core` for 32 iterations. It applies MIPS sign correction, stalls the pipeline until the result is ready, and presents the 64-bit {HI, LO} result to the HI/LO write path. Exceptions and branch flushes cancel it cleanly.

---
 rtl/div_ctrl_pkg.sv | 19 +
 rtl/div_ctrl_core.sv | 68 ++++++
 rtl/div_ctrl.sv | 125 ++++++++++++
 tb/tb_div_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the EX-stage divide sequencer: FSM encodings,
// core start/stop levels and the nominal accept-to-valid latency.
package div_ctrl_pkg;

   typedef enum logic [2:0] {
      DIV_IDLE = 3'd0,
      DIV_PREP = 3'd1,
      DIV_RUN  = 3'd2,
      DIV_FIX  = 3'd3,
      DIV_DONE = 3'd4
   } div_state_e;

   localparam logic DIV_START = 1'b1;
   localparam logic DIV_STOP  = 1'b0;

   // Accept-to-valid cycles for WIDTH = 32: PREP + 32 x RUN + FIX + 1.
   localparam int unsigned DIV_LAT = 35;

endpackage

// File: rtl/div_ctrl_core.sv
// Unsigned restoring divider: one shift-subtract step per cycle, WIDTH steps.
// done_o is high during the final step so the caller can leave on that edge.
module div_core #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             done_o,
   output logic [WIDTH-1:0] quot_o,
   output logic [WIDTH-1:0] rem_o
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic             busy_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] dsr_q;
   logic [WIDTH-1:0] quot_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH:0]   partial;
   logic [WIDTH:0]   diff;

   // Borrow out of diff means the shifted remainder is below the divisor.
   always_comb begin
      partial = {rem_q, quot_q[WIDTH-1]};
      diff    = partial - {1'b0, dsr_q};
   end

   assign done_o = busy_q & (cnt_q == CW'(WIDTH - 1));
   assign quot_o = quot_q;
   assign rem_o  = rem_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         dsr_q  <= '0;
         quot_q <= '0;
         rem_q  <= '0;
      end else if (abort_i) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else if (start_i) begin
         busy_q <= 1'b1;
         cnt_q  <= '0;
         dsr_q  <= divisor_i;
         quot_q <= dividend_i;
         rem_q  <= '0;
      end else if (busy_q) begin
         if (!diff[WIDTH]) begin
            rem_q  <= diff[WIDTH-1:0];
            quot_q <= {quot_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_q  <= partial[WIDTH-1:0];
            quot_q <= {quot_q[WIDTH-2:0], 1'b0};
         end
         cnt_q <= cnt_q + CW'(1);
         if (done_o) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/div_ctrl.sv
// EX-stage DIV/DIVU sequencer: latches operands, runs div_core, applies MIPS
// sign correction and holds the pipeline until {HI, LO} is ready.
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               signed_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   input  logic               flush_i,
   input  logic               stall_i,
   output logic               stall_o,
   output logic               valid_o,
   output logic [2*WIDTH-1:0] result_o,
   output logic               div_zero_o
);

   div_state_e       state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             signed_q;
   logic             q_neg_q;
   logic             r_neg_q;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic             b_zero;
   logic             core_start;
   logic             core_done;
   logic [WIDTH-1:0] core_quot;
   logic [WIDTH-1:0] core_rem;

   assign b_zero     = (b_q == '0);
   assign mag_a      = (signed_q & a_q[WIDTH-1]) ? (~a_q + WIDTH'(1)) : a_q;
   assign mag_b      = (signed_q & b_q[WIDTH-1]) ? (~b_q + WIDTH'(1)) : b_q;
   assign core_start = ((state_q == DIV_PREP) & ~flush_i & ~b_zero) ? DIV_START : DIV_STOP;

   // Hazard request; gated by reset so it reads 0 while reset is asserted.
   assign stall_o = ~rst & ~flush_i &
                    (((state_q == DIV_IDLE) & start_i) |
                     (state_q == DIV_PREP) |
                     (state_q == DIV_RUN)  |
                     (state_q == DIV_FIX));

   div_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk        (clk),
      .rst        (rst),
      .start_i    (core_start),
      .abort_i    (flush_i),
      .dividend_i (mag_a),
      .divisor_i  (mag_b),
      .done_o     (core_done),
      .quot_o     (core_quot),
      .rem_o      (core_rem)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= DIV_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         signed_q   <= 1'b0;
         q_neg_q    <= 1'b0;
         r_neg_q    <= 1'b0;
         valid_o    <= 1'b0;
         result_o   <= '0;
         div_zero_o <= 1'b0;
      end else if (flush_i) begin
         state_q <= DIV_IDLE;
         valid_o <= 1'b0;
      end else begin
         case (state_q)
            DIV_IDLE: begin
               if (start_i) begin
                  a_q      <= a_i;
                  b_q      <= b_i;
                  signed_q <= signed_i;
                  state_q  <= DIV_PREP;
               end
            end
            DIV_PREP: begin
               if (b_zero) begin
                  result_o   <= {a_q, {WIDTH{1'b1}}};
                  div_zero_o <= 1'b1;
                  valid_o    <= 1'b1;
                  state_q    <= DIV_DONE;
               end else begin
                  q_neg_q    <= signed_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                  r_neg_q    <= signed_q & a_q[WIDTH-1];
                  div_zero_o <= 1'b0;
                  state_q    <= DIV_RUN;
               end
            end
            DIV_RUN: begin
               if (core_done) begin
                  state_q <= DIV_FIX;
               end
            end
            DIV_FIX: begin
               result_o <= {(r_neg_q ? (~core_rem + WIDTH'(1)) : core_rem),
                            (q_neg_q ? (~core_quot + WIDTH'(1)) : core_quot)};
               valid_o  <= 1'b1;
               state_q  <= DIV_DONE;
            end
            DIV_DONE: begin
               // A still-high start_i here belongs to the finishing instruction.
               if (!stall_i) begin
                  valid_o <= 1'b0;
                  state_q <= DIV_IDLE;
               end
            end
            default: begin
               state_q <= DIV_IDLE;
               valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: vector table of divides plus flush, held-result
// and asynchronous-reset sequences.
module tb_div_ctrl;
   import div_ctrl_pkg::*;

   localparam int unsigned W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic          signed_i;
   logic [W-1:0]  a_i;
   logic [W-1:0]  b_i;
   logic          flush_i;
   logic          stall_i;
   logic          stall_o;
   logic          valid_o;
   logic [2*W-1:0] result_o;
   logic          div_zero_o;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic           sgn;
      logic [2*W-1:0] res;
      logic           zero;
      int             lat;
   } vec_t;

   vec_t vecs[14];

   div_ctrl #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .signed_i   (signed_i),
      .a_i        (a_i),
      .b_i        (b_i),
      .flush_i    (flush_i),
      .stall_i    (stall_i),
      .stall_o    (stall_o),
      .valid_o    (valid_o),
      .result_o   (result_o),
      .div_zero_o (div_zero_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Starts at posedge+1 in IDLE; returns at the negedge of the first DONE cycle.
   task automatic div_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         input logic [2*W-1:0] exp_res, input logic exp_zero,
                         input int exp_lat, input string tag);
      int lat;
      logic stall_ok;
      a_i = a; b_i = b; signed_i = sgn; start_i = 1'b1;
      lat = 0;
      stall_ok = 1'b1;
      @(negedge clk);
      chk({tag, "_accept_stall"}, 64'(stall_o), 64'd1);
      while (!valid_o && lat < 100) begin
         @(posedge clk); #1;
         lat++;
         @(negedge clk);
         if (!valid_o && !stall_o) stall_ok = 1'b0;
      end
      chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_result"}, result_o, exp_res);
      chk({tag, "_div_zero"}, 64'(div_zero_o), 64'(exp_zero));
      chk({tag, "_done_stall_low"}, 64'(stall_o), 64'd0);
      chk({tag, "_stall_while_busy"}, 64'(stall_ok), 64'd1);
   endtask

   // Leaves DONE with stall_i low; checks IDLE and the held result; returns at posedge+1.
   task automatic exit_done(input logic [2*W-1:0] exp_res, input string tag);
      @(posedge clk); #1;
      start_i = 1'b0;
      @(negedge clk);
      chk({tag, "_idle_valid"}, 64'(valid_o), 64'd0);
      chk({tag, "_idle_stall"}, 64'(stall_o), 64'd0);
      chk({tag, "_result_kept"}, result_o, exp_res);
      @(posedge clk); #1;
   endtask

   initial begin
      vecs[0]  = '{32'd100,       32'd7,         1'b0, {32'h00000002, 32'h0000000E}, 1'b0, DIV_LAT};
      vecs[1]  = '{32'hFFFFFFF9,  32'd2,         1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, DIV_LAT};
      vecs[2]  = '{32'd7,         32'hFFFFFFFE,  1'b1, {32'h00000001, 32'hFFFFFFFD}, 1'b0, DIV_LAT};
      vecs[3]  = '{32'h80000000,  32'hFFFFFFFF,  1'b1, {32'h00000000, 32'h80000000}, 1'b0, DIV_LAT};
      vecs[4]  = '{32'd5,         32'd0,         1'b0, {32'h00000005, 32'hFFFFFFFF}, 1'b1, 2};
      vecs[5]  = '{32'd9,         32'd3,         1'b0, {32'h00000000, 32'h00000003}, 1'b0, DIV_LAT};
      vecs[6]  = '{32'hFFFFFFFF,  32'd1,         1'b0, {32'h00000000, 32'hFFFFFFFF}, 1'b0, DIV_LAT};
      vecs[7]  = '{32'hFFFFFFFF,  32'd2,         1'b0, {32'h00000001, 32'h7FFFFFFF}, 1'b0, DIV_LAT};
      vecs[8]  = '{32'hFFFFFFFF,  32'd2,         1'b1, {32'hFFFFFFFF, 32'h00000000}, 1'b0, DIV_LAT};
      vecs[9]  = '{32'hFFFFFF9C,  32'hFFFFFFF9,  1'b1, {32'hFFFFFFFE, 32'h0000000E}, 1'b0, DIV_LAT};
      vecs[10] = '{32'd3,         32'd5,         1'b0, {32'h00000003, 32'h00000000}, 1'b0, DIV_LAT};
      vecs[11] = '{32'hFFFFFFFB,  32'd0,         1'b1, {32'hFFFFFFFB, 32'hFFFFFFFF}, 1'b1, 2};
      vecs[12] = '{32'h80000000,  32'h80000000,  1'b1, {32'h00000000, 32'h00000001}, 1'b0, DIV_LAT};
      vecs[13] = '{32'h80000000,  32'hFFFFFFFF,  1'b0, {32'h80000000, 32'h00000000}, 1'b0, DIV_LAT};

      rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; a_i = '0; b_i = '0;
      flush_i = 1'b0; stall_i = 1'b0;
      @(negedge clk);
      chk("reset_stall", 64'(stall_o), 64'd0);
      chk("reset_valid", 64'(valid_o), 64'd0);
      chk("reset_result", result_o, 64'd0);
      chk("reset_div_zero", 64'(div_zero_o), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 14; i++) begin
         div_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].res, vecs[i].zero,
                vecs[i].lat, $sformatf("vec%0d", i));
         exit_done(vecs[i].res, $sformatf("vec%0d", i));
      end

      // Flush at t+10 of a running divide, then a fresh 9/3 accepted at t+12.
      begin
         logic seen_valid;
         seen_valid = 1'b0;
         a_i = 32'd100; b_i = 32'd7; signed_i = 1'b0; start_i = 1'b1;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (valid_o) seen_valid = 1'b1;
            @(posedge clk); #1;
         end
         flush_i = 1'b1;
         @(negedge clk);
         chk("flush_stall_same_cycle", 64'(stall_o), 64'd0);
         if (valid_o) seen_valid = 1'b1;
         @(posedge clk); #1;
         flush_i = 1'b0; start_i = 1'b0;
         @(negedge clk);
         chk("flush_idle_stall", 64'(stall_o), 64'd0);
         if (valid_o) seen_valid = 1'b1;
         chk("flush_never_valid", 64'(seen_valid), 64'd0);
         @(posedge clk); #1;
         div_op(32'd9, 32'd3, 1'b0, {32'h0, 32'h3}, 1'b0, DIV_LAT, "after_flush");
         exit_done({32'h0, 32'h3}, "after_flush");
      end

      // Held result while stall_i is high in DONE with start_i still high.
      div_op(32'd50, 32'd5, 1'b0, {32'h0, 32'd10}, 1'b0, DIV_LAT, "hold");
      stall_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk($sformatf("hold%0d_valid", i), 64'(valid_o), 64'd1);
         chk($sformatf("hold%0d_result", i), result_o, {32'h0, 32'd10});
         chk($sformatf("hold%0d_stall", i), 64'(stall_o), 64'd0);
      end
      stall_i = 1'b0;
      exit_done({32'h0, 32'd10}, "hold");

      // Asynchronous reset in the middle of RUN.
      a_i = 32'd100; b_i = 32'd7; signed_i = 1'b0; start_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("pre_reset_stall", 64'(stall_o), 64'd1);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("async_reset_stall", 64'(stall_o), 64'd0);
      chk("async_reset_valid", 64'(valid_o), 64'd0);
      chk("async_reset_result", result_o, 64'd0);
      chk("async_reset_div_zero", 64'(div_zero_o), 64'd0);
      @(posedge clk); #1;
      start_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      div_op(32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, 1'b0, DIV_LAT, "post_reset");
      exit_done({32'h2, 32'hE}, "post_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
